// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM duty/period measurement block.
// Optional glitch filter is enabled by defining PWM_MEAS_GLITCH_FILT_EN.
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

  localparam int CNT_W_DEF   = 12;
  localparam int TIMEOUT_DEF = 4095;

  // All-ones value of a width-bit counter; reported as high_time when stuck high.
  function automatic logic [31:0] sat_max(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer, optional glitch filter (PWM_MEAS_GLITCH_FILT_EN) and
// edge detector producing the clean level and one-cycle rise/fall strobes.
module pwm_edge_sync
`ifdef PWM_MEAS_GLITCH_FILT_EN
#(
  parameter int FILT_LEN = 3
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic s_lvl,
  output logic rise,
  output logic fall
);

`ifdef PWM_MEAS_GLITCH_FILT_EN
  localparam int WARM = 4;
`else
  localparam int WARM = 3;
`endif

  logic            sync1;
  logic            sync2;
  logic            s_prv;
  logic [WARM-1:0] fill;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its source and the chain cannot collapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s_prv <= 1'b0;
      fill  <= '0;
    end else begin
      sync1 <= pwm;
      sync2 <= sync1;
      s_prv <= s_lvl;
      fill  <= {fill[WARM-2:0], 1'b1};
    end
  end

`ifdef PWM_MEAS_GLITCH_FILT_EN
  localparam int             FCW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

  logic [FCW-1:0] run_cnt;
  logic           filt_lvl;

  // Until real samples reach sync2 the filter is bypassed, so an input that is
  // already high at reset release does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_lvl <= 1'b0;
      run_cnt  <= '0;
    end else if (!fill[2]) begin
      filt_lvl <= sync2;
      run_cnt  <= '0;
    end else if (sync2 == filt_lvl) begin
      run_cnt  <= '0;
    end else if (run_cnt == FILT_LAST) begin
      filt_lvl <= sync2;
      run_cnt  <= '0;
    end else begin
      run_cnt  <= run_cnt + FCW'(1);
    end
  end

  assign s_lvl = filt_lvl;
`else
  assign s_lvl = sync2;
`endif

  // Edges are suppressed while the pipeline still holds reset values.
  assign rise = fill[WARM-1] &  s_lvl & ~s_prv;
  assign fall = fill[WARM-1] & ~s_lvl &  s_prv;

endmodule

// File: rtl/pwm_duty_meas.sv
// PWM high-time / period meter with stuck-input detection.
// Define PWM_MEAS_GLITCH_FILT_EN to add a FILT_LEN-sample glitch filter.
module pwm_duty_meas
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
`ifdef PWM_MEAS_GLITCH_FILT_EN
  , parameter int FILT_LEN = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PWM_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             vld,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic s_lvl;
  logic rise;
  logic fall;

  pwm_edge_sync
`ifdef PWM_MEAS_GLITCH_FILT_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm   (PWM_in),
    .s_lvl (s_lvl),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_nxt;
  logic [CNT_W-1:0] high_time_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             stuck_nxt;
  logic             stuck_lvl_nxt;
  logic             pub;
  logic             enter_stuck;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT) ? v : v + ONE;
  endfunction

  // >= rather than == so a saturated or overshot counter still times out.
  assign timeout = (per_cnt >= TO);

  // NOTE: every signal assigned here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    per_nxt       = per_cnt;
    hi_nxt        = hi_cnt;
    high_time_nxt = high_time;
    period_nxt    = period;
    stuck_nxt     = stuck;
    stuck_lvl_nxt = stuck_lvl;
    pub           = 1'b0;
    enter_stuck   = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          per_nxt   = ONE;
          hi_nxt    = ONE;
        end else if (timeout) begin
          enter_stuck = 1'b1;
        end else begin
          per_nxt = sat_inc(per_cnt);
        end
      end

      HIGH: begin
        if (timeout) begin
          enter_stuck = 1'b1;
        end else if (fall) begin
          state_nxt = LOW;
          per_nxt   = sat_inc(per_cnt);
        end else begin
          per_nxt = sat_inc(per_cnt);
          hi_nxt  = sat_inc(hi_cnt);
        end
      end

      LOW: begin
        // A rise on the timeout cycle still closes a valid period.
        if (rise) begin
          high_time_nxt = hi_cnt;
          period_nxt    = per_cnt;
          stuck_nxt     = 1'b0;
          pub           = 1'b1;
          state_nxt     = HIGH;
          per_nxt       = ONE;
          hi_nxt        = ONE;
        end else if (timeout) begin
          enter_stuck = 1'b1;
        end else begin
          per_nxt = sat_inc(per_cnt);
        end
      end

      STUCK: begin
        if (rise) begin
          stuck_nxt = 1'b0;
          state_nxt = HIGH;
          per_nxt   = ONE;
          hi_nxt    = ONE;
        end else if (fall) begin
          stuck_lvl_nxt = 1'b0;
          state_nxt     = LOW;
          per_nxt       = ONE;
          hi_nxt        = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (enter_stuck) begin
      state_nxt     = STUCK;
      high_time_nxt = s_lvl ? SAT : '0;
      period_nxt    = '0;
      stuck_nxt     = 1'b1;
      stuck_lvl_nxt = s_lvl;
      pub           = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      high_time <= '0;
      period    <= '0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
      vld       <= 1'b0;
    end else begin
      state     <= state_nxt;
      per_cnt   <= per_nxt;
      hi_cnt    <= hi_nxt;
      high_time <= high_time_nxt;
      period    <= period_nxt;
      stuck     <= stuck_nxt;
      stuck_lvl <= stuck_lvl_nxt;
      vld       <= pub;
    end
  end

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Scoreboard bench for pwm_duty_meas driven by an 11-bit PWM generator model
// and hand-shaped waveforms; honours PWM_MEAS_GLITCH_FILT_EN for glitch cases.
module tb_pwm_duty_meas;

  localparam int CNT_W      = 12;
  localparam int PWM_PERIOD = 2048;

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] per;
    logic             stk;
    logic             lvl;
  } rep_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             PWM_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             vld;
  logic             stuck;
  logic             stuck_lvl;

  int   checks = 0;
  int   errors = 0;
  rep_t exp_q[$];

  int gen_cnt   = 0;
  int duty      = 0;
  int glitch_lo = 0;
  int glitch_hi = 0;
  logic prev_vld = 1'b0;

  always #5 clk = ~clk;

  pwm_duty_meas dut (
    .clk       (clk),
    .rst       (rst),
    .PWM_in    (PWM_in),
    .high_time (high_time),
    .period    (period),
    .vld       (vld),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl)
  );

  function automatic rep_t mk(input int hi, input int per, input logic stk, input logic lvl);
    rep_t r;
    r.hi  = CNT_W'(hi);
    r.per = CNT_W'(per);
    r.stk = stk;
    r.lvl = lvl;
    return r;
  endfunction

  // Scoreboard: every vld pulse pops one expected report.
  always @(negedge clk) begin
    if (vld && prev_vld) begin
      checks++;
      errors++;
      $display("FAIL vld_back_to_back: vld high on two consecutive cycles");
    end
    if (vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: got hi=%0d per=%0d stuck=%0b lvl=%0b, no report expected",
                 high_time, period, stuck, stuck_lvl);
      end else begin
        rep_t e;
        e = exp_q.pop_front();
        if ({high_time, period, stuck, stuck_lvl} !== e) begin
          errors++;
          $display("FAIL report: got hi=%0d per=%0d stuck=%0b lvl=%0b, want hi=%0d per=%0d stuck=%0b lvl=%0b",
                   high_time, period, stuck, stuck_lvl, e.hi, e.per, e.stk, e.lvl);
        end
      end
    end
    prev_vld = vld;
  end

  task automatic gen_step();
    int c;
    @(negedge clk);
    c = gen_cnt % PWM_PERIOD;
    PWM_in = (c < duty) && !(c >= glitch_lo && c < glitch_hi);
    gen_cnt++;
  endtask

  task automatic run_cycles(input int d, input int n);
    duty = d;
    repeat (n) gen_step();
  endtask

  // Runs through n generator rises, stopping 8 cycles into the next period.
  task automatic run_periods(input int d, input int n);
    run_cycles(d, n * PWM_PERIOD - (gen_cnt % PWM_PERIOD) + 8);
  endtask

  task automatic drive_level(input logic lvl, input int n);
    repeat (n) begin
      @(negedge clk);
      PWM_in = lvl;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    PWM_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({high_time, period} !== '0) begin
      errors++;
      $display("FAIL reset_counts: got hi=%0d per=%0d, want 0 0", high_time, period);
    end
    checks++;
    if ({vld, stuck, stuck_lvl} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got vld/stuck/lvl=%b, want 000", {vld, stuck, stuck_lvl});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    gen_cnt = 0;
    // Five rises: the first opens a partial period, the rest each close one.
    repeat (4) exp_q.push_back(mk(1024, 2048, 1'b0, 1'b0));
    run_periods(32'h400, 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal_reports: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_duty_change();
    // Change lands 8 cycles into a high phase that began at count 0.
    repeat (3) exp_q.push_back(mk(2047, 2048, 1'b0, 1'b0));
    run_periods(2047, 3);
    exp_q.push_back(mk(8, 2048, 1'b0, 1'b0));
    repeat (2) exp_q.push_back(mk(1, 2048, 1'b0, 1'b0));
    run_periods(1, 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL duty_change_reports: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stuck_low();
    exp_q.push_back(mk(0, 0, 1'b1, 1'b0));
    run_cycles(0, 6000);
    checks++;
    if (exp_q.size() != 0 || stuck !== 1'b1 || stuck_lvl !== 1'b0) begin
      errors++;
      $display("FAIL stuck_low: got outstanding=%0d stuck=%b lvl=%b, want 0 1 0",
               exp_q.size(), stuck, stuck_lvl);
      exp_q.delete();
    end
    run_periods(32'h200, 1);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_low_clear: got stuck=%b, want 0", stuck);
    end
    exp_q.push_back(mk(512, 2048, 1'b0, 1'b0));
    run_periods(32'h200, 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stuck_low_recover: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stuck_high();
    exp_q.push_back(mk(4095, 0, 1'b1, 1'b1));
    drive_level(1'b1, 5000);
    checks++;
    if (exp_q.size() != 0 || stuck !== 1'b1 || stuck_lvl !== 1'b1 || high_time !== 12'hfff) begin
      errors++;
      $display("FAIL stuck_high: got outstanding=%0d stuck=%b lvl=%b hi=%0d, want 0 1 1 4095",
               exp_q.size(), stuck, stuck_lvl, high_time);
      exp_q.delete();
    end
    // Generator takes over in its high phase; the fall leaves stuck set but drops stuck_lvl.
    gen_cnt = 0;
    run_cycles(32'h400, 1100);
    checks++;
    if (stuck !== 1'b1 || stuck_lvl !== 1'b0) begin
      errors++;
      $display("FAIL stuck_high_fall: got stuck=%b lvl=%b, want 1 0", stuck, stuck_lvl);
    end
    exp_q.push_back(mk(0, 1024, 1'b0, 1'b0));
    exp_q.push_back(mk(1024, 2048, 1'b0, 1'b0));
    run_periods(32'h400, 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stuck_high_recover: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    run_cycles(32'h400, 492);
    gen_step();
    rst = 1'b1;
    gen_step();
    rst = 1'b0;
    checks++;
    if ({high_time, period, vld, stuck, stuck_lvl} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got hi=%0d per=%0d vld=%b stuck=%b lvl=%b, want all 0",
               high_time, period, vld, stuck, stuck_lvl);
    end
    // The high phase in progress and the next rise are ignored; one full period follows.
    exp_q.push_back(mk(1024, 2048, 1'b0, 1'b0));
    run_periods(32'h400, 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_reports: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    glitch_lo = 400;
    glitch_hi = 402;
`ifdef PWM_MEAS_GLITCH_FILT_EN
    exp_q.push_back(mk(1024, 2048, 1'b0, 1'b0));
`else
    exp_q.push_back(mk(400, 402, 1'b0, 1'b0));
    exp_q.push_back(mk(622, 1646, 1'b0, 1'b0));
`endif
    run_periods(32'h400, 1);
    glitch_lo = 0;
    glitch_hi = 0;
    exp_q.push_back(mk(1024, 2048, 1'b0, 1'b0));
    run_periods(32'h400, 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_reports: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rise_vs_timeout();
    // Current high phase has lasted 8 cycles since its rise.
    exp_q.push_back(mk(8, 108, 1'b0, 1'b0));
    exp_q.push_back(mk(100, 4095, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 0, 1'b1, 1'b0));
    exp_q.push_back(mk(100, 200, 1'b0, 1'b0));
    drive_level(1'b0, 100);
    drive_level(1'b1, 100);
    drive_level(1'b0, 3995);
    drive_level(1'b1, 100);
    drive_level(1'b0, 3996);
    drive_level(1'b1, 100);
    checks++;
    if (stuck !== 1'b0 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_then_rise: got stuck=%b outstanding=%0d, want 0 1", stuck, exp_q.size());
    end
    drive_level(1'b0, 100);
    drive_level(1'b1, 50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rise_vs_timeout_reports: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_duty_change();
    test_stuck_low();
    test_stuck_high();
    test_mid_reset();
    test_glitch();
    test_rise_vs_timeout();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
